// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: buffers CPU store bytes bound for the UART and hands them
// to the uart core one at a time. Each strobe waits for the core to go idle
// and then for a programmable gap. When the queue is full, the block either
// stalls the pipeline or drops the byte and sets a sticky overflow flag.
module uart_tx_scheduler #(
  parameter int DEPTH        = 16,
  parameter int GAP_CYCLES   = 2,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     uart_busy,
  output logic                     uart_wr,
  output logic [7:0]               uart_dat,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      dat_q, dat_d;
  logic            ovf_q, ovf_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            start;

  // Full/empty come from the registered count, so a pop in this cycle never
  // makes room for a write in the same cycle. flush blocks both push and start.
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    push  = wr_en && !full && !flush;
    start = (state_q == IDLE) && !empty && !uart_busy && !flush;
  end

  // Queue storage has no reset; only the pointers and the count say what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= wr_data;
  end

  // Pointer, count and overflow bookkeeping. flush overrides any push or pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push)  wrPtr_d = wrPtr_q + 1'b1;
      if (start) rdPtr_d = rdPtr_q + 1'b1;
      if (push && !start)      count_d = count_q + 1'b1;
      else if (!push && start) count_d = count_q - 1'b1;
      if (DROP_ON_FULL && wr_en && full) ovf_d = 1'b1;
    end
  end

  // Transmit sequencing: pop into SEND, wait out the core's busy time, then the gap.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          dat_d   = mem_q[rdPtr_q];
        end
      end
      SEND: state_d = HOLD;
      HOLD: begin
        if (!uart_busy) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      gap_q   <= '0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
    end
  end

  // Output decode: the strobe lasts exactly the SEND cycle; stall exists only in stalling mode.
  always_comb begin
    uart_wr    = (state_q == SEND);
    uart_dat   = dat_q;
    stall      = DROP_ON_FULL ? 1'b0 : (wr_en && full);
    fifo_count = count_q;
    fifo_empty = empty;
    fifo_full  = full;
    overflow   = ovf_q;
  end

endmodule
